fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core.
- Directly upstream of the decode stage; consumes the hazard unit's StallF, StallD and FlushD outputs, plus PCSrcE/PCTargetE from execute.
- Owns the PC register and a request/valid handshake to instruction memory that may insert wait states.
- Presents InstrD/PCD/PCPlus4D to decode, or a NOP bubble when no instruction is available.

---
 rtl/fetch_stage.sv | 185 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RISC-V
// core. Owns the fetch PC (PCF) and runs a request/valid handshake towards
// instruction memory, which may insert any number of wait states. Completed
// fetches are written straight into the IF/ID register on the same edge; when
// no instruction is available decode sees a NOP bubble with ValidD=0.
//
// Ports
//   clk         in   1   core clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   StallF      in   1   hold PC / fetch state (hazard unit)
//   StallD      in   1   hold IF/ID register (hazard unit)
//   FlushD      in   1   clear IF/ID register to a bubble (hazard unit)
//   PCSrcE      in   1   taken branch/jump resolved in execute
//   PCTargetE   in   32  redirect target, bits [1:0] ignored
//   imem_req    out  1   fetch request
//   imem_addr   out  32  fetch address (PCF)
//   imem_rdata  in   32  instruction word, meaningful when imem_valid=1
//   imem_valid  in   1   response for the current request (may be zero-wait)
//   InstrD      out  32  decode-stage instruction
//   PCD         out  32  PC of InstrD
//   PCPlus4D    out  32  PCD + 4
//   ValidD      out  1   1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // IDLE : one quiet cycle after reset, no request
    // FETCH: request outstanding at PCF
    // DRAIN: redirect arrived mid-request; finish the old request, then jump
    // HOLD : response arrived while stalled; word parked until stall releases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetchState_t;

    fetchState_t stateReg;
    logic        reqReg;
    logic [31:0] pcReg;
    logic [31:0] pendingTargetReg;
    logic [31:0] holdInstrReg;

    logic [31:0] targetAligned;
    logic [31:0] pcPlus4;
    logic        deliver;
    logic [31:0] deliverInstr;

    // Targets are forced word-aligned so imem_addr[1:0] can never be non-zero.
    assign targetAligned = {PCTargetE[31:2], 2'b00};
    assign pcPlus4       = pcReg + 32'd4;   // wraps modulo 2^32

    assign imem_req  = reqReg;
    assign imem_addr = pcReg;

    // Which word (if any) goes into IF/ID this edge. The PC of a delivered word
    // is always the current PCF: in HOLD the PC was frozen when the word was
    // parked, so it still names the held word.
    always_comb begin
        deliver      = 1'b0;
        deliverInstr = imem_rdata;
        case (stateReg)
            FETCH: begin
                deliver = imem_valid & ~PCSrcE & ~StallF;
            end
            HOLD: begin
                deliver      = ~PCSrcE & ~StallF;
                deliverInstr = holdInstrReg;
            end
            default: begin
                deliver = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg         <= IDLE;
            reqReg           <= 1'b0;
            pcReg            <= {RESET_PC[31:2], 2'b00};
            pendingTargetReg <= 32'd0;
            holdInstrReg     <= 32'd0;
            InstrD           <= NOP_INSTR;
            PCD              <= 32'd0;
            PCPlus4D         <= 32'd0;
            ValidD           <= 1'b0;
        end else begin
            // ---------------- fetch state machine ----------------
            case (stateReg)
                IDLE: begin
                    stateReg <= FETCH;
                    reqReg   <= 1'b1;
                end

                FETCH: begin
                    if (imem_valid) begin
                        if (PCSrcE) begin
                            // Wrong-path response: drop it and refetch.
                            pcReg <= targetAligned;
                        end else if (StallF) begin
                            // Park the word; PCF stays put and names it.
                            holdInstrReg <= imem_rdata;
                            stateReg     <= HOLD;
                            reqReg       <= 1'b0;
                        end else begin
                            pcReg <= pcPlus4;
                        end
                    end else if (PCSrcE) begin
                        // Address must stay stable until the response, so
                        // remember where to go once the old request drains.
                        pendingTargetReg <= targetAligned;
                        stateReg         <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (imem_valid) begin
                        pcReg    <= PCSrcE ? targetAligned : pendingTargetReg;
                        stateReg <= FETCH;
                    end else if (PCSrcE) begin
                        pendingTargetReg <= targetAligned;
                    end
                end

                HOLD: begin
                    if (PCSrcE) begin
                        pcReg    <= targetAligned;
                        stateReg <= FETCH;
                        reqReg   <= 1'b1;
                    end else if (!StallF) begin
                        pcReg    <= pcPlus4;
                        stateReg <= FETCH;
                        reqReg   <= 1'b1;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    reqReg   <= 1'b0;
                end
            endcase

            // ---------------- IF/ID register ----------------
            if (FlushD) begin
                InstrD   <= NOP_INSTR;
                PCD      <= 32'd0;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end else if (!StallD) begin
                if (deliver) begin
                    InstrD   <= deliverInstr;
                    PCD      <= pcReg;
                    PCPlus4D <= pcPlus4;
                    ValidD   <= 1'b1;
                end else begin
                    // Bubble: PCD/PCPlus4D keep their last values.
                    InstrD <= NOP_INSTR;
                    ValidD <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small instruction-memory model answers each
// request after a programmable number of wait states (or from a manual valid
// override). Inputs change and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int compared   = 0;
    int mismatched = 0;

    // memory model controls
    int   waitStates = 0;
    int   waitCnt    = 0;
    logic manualMode = 1'b0;
    logic manualValid = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    // Memory contents: address 0 holds addi x1,x0,10; elsewhere a tagged address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'd0) ? 32'h00A0_0093 : (32'h1000_0000 | a);
    endfunction

    assign imem_rdata = memWord(imem_addr);

    always_comb begin
        if (manualMode) imem_valid = manualValid;
        else            imem_valid = imem_req && (waitCnt >= waitStates);
    end

    always @(posedge clk) begin
        if (!imem_req || imem_valid) waitCnt <= 0;
        else                         waitCnt <= waitCnt + 1;
    end

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        repeat (2) @(negedge clk);
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %h want 0", imem_req); end
        compared++; if (InstrD !== NOP) begin mismatched++; $display("FAIL reset_instr: got %h want %h", InstrD, NOP); end
        compared++; if (PCD !== 32'd0) begin mismatched++; $display("FAIL reset_pcd: got %h want 0", PCD); end
        compared++; if (PCPlus4D !== 32'd0) begin mismatched++; $display("FAIL reset_pcp4: got %h want 0", PCPlus4D); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %h want 0", ValidD); end
        compared++; if (imem_addr !== 32'd0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        rst = 1'b0;
        @(negedge clk);
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL first_req: got %h want 1", imem_req); end
        compared++; if (imem_addr !== 32'd0) begin mismatched++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL idle_valid: got %h want 0", ValidD); end
        $display("test_reset: reset values and first request checked");
    endtask

    task automatic test_zero_wait;
        @(negedge clk);
        compared++; if (InstrD !== 32'h00A0_0093) begin mismatched++; $display("FAIL zw_instr0: got %h want 00a00093", InstrD); end
        compared++; if (PCD !== 32'h0) begin mismatched++; $display("FAIL zw_pcd0: got %h want 0", PCD); end
        compared++; if (PCPlus4D !== 32'h4) begin mismatched++; $display("FAIL zw_pcp4_0: got %h want 4", PCPlus4D); end
        compared++; if (ValidD !== 1'b1) begin mismatched++; $display("FAIL zw_valid0: got %h want 1", ValidD); end
        compared++; if (imem_addr !== 32'h4) begin mismatched++; $display("FAIL zw_addr0: got %h want 4", imem_addr); end
        @(negedge clk);
        compared++; if (PCD !== 32'h4) begin mismatched++; $display("FAIL zw_pcd1: got %h want 4", PCD); end
        compared++; if (InstrD !== 32'h1000_0004) begin mismatched++; $display("FAIL zw_instr1: got %h want 10000004", InstrD); end
        compared++; if (imem_addr !== 32'h8) begin mismatched++; $display("FAIL zw_addr1: got %h want 8", imem_addr); end
        $display("test_zero_wait: PCD 0 then 4 delivered back to back");
    endtask

    task automatic test_wait_states;
        waitStates = 2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL ws_bubble%0d: got %h want 0", i, ValidD); end
            compared++; if (imem_addr !== 32'h8) begin mismatched++; $display("FAIL ws_addr%0d: got %h want 8", i, imem_addr); end
            compared++; if (PCD !== 32'h4) begin mismatched++; $display("FAIL ws_pcdhold%0d: got %h want 4", i, PCD); end
        end
        @(negedge clk);
        compared++; if (PCD !== 32'h8) begin mismatched++; $display("FAIL ws_pcd: got %h want 8", PCD); end
        compared++; if (ValidD !== 1'b1) begin mismatched++; $display("FAIL ws_valid: got %h want 1", ValidD); end
        compared++; if (InstrD !== 32'h1000_0008) begin mismatched++; $display("FAIL ws_instr: got %h want 10000008", InstrD); end
        compared++; if (imem_addr !== 32'hC) begin mismatched++; $display("FAIL ws_pcf: got %h want c", imem_addr); end
        waitStates = 0;
        $display("test_wait_states: two wait states at 0x8 checked");
    endtask

    task automatic test_stall;
        @(negedge clk);
        compared++; if (imem_addr !== 32'h10) begin mismatched++; $display("FAIL st_addr: got %h want 10", imem_addr); end
        StallF = 1; StallD = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL st_req%0d: got %h want 0", i, imem_req); end
            compared++; if (InstrD !== 32'h1000_000C) begin mismatched++; $display("FAIL st_frozen%0d: got %h want 1000000c", i, InstrD); end
            compared++; if (PCD !== 32'hC) begin mismatched++; $display("FAIL st_pcd%0d: got %h want c", i, PCD); end
        end
        StallF = 0; StallD = 0;
        @(negedge clk);
        compared++; if (PCD !== 32'h10) begin mismatched++; $display("FAIL st_rel_pcd: got %h want 10", PCD); end
        compared++; if (InstrD !== 32'h1000_0010) begin mismatched++; $display("FAIL st_rel_instr: got %h want 10000010", InstrD); end
        compared++; if (ValidD !== 1'b1) begin mismatched++; $display("FAIL st_rel_valid: got %h want 1", ValidD); end
        compared++; if (imem_addr !== 32'h14) begin mismatched++; $display("FAIL st_rel_pcf: got %h want 14", imem_addr); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL st_rel_req: got %h want 1", imem_req); end
        $display("test_stall: word at 0x10 parked in HOLD and released");
    endtask

    task automatic test_redirect_drain;
        repeat (3) @(negedge clk);
        compared++; if (imem_addr !== 32'h20) begin mismatched++; $display("FAIL dr_start: got %h want 20", imem_addr); end
        waitStates = 2;
        @(negedge clk);
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL dr_wait_valid: got %h want 0", ValidD); end
        PCSrcE = 1; PCTargetE = 32'h100;
        @(negedge clk);
        compared++; if (imem_addr !== 32'h20) begin mismatched++; $display("FAIL dr_addr_stable: got %h want 20", imem_addr); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL dr_valid0: got %h want 0", ValidD); end
        PCSrcE = 0; PCTargetE = 32'h0;
        @(negedge clk);
        compared++; if (imem_addr !== 32'h100) begin mismatched++; $display("FAIL dr_newaddr: got %h want 100", imem_addr); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL dr_valid1: got %h want 0", ValidD); end
        compared++; if (PCD !== 32'h1C) begin mismatched++; $display("FAIL dr_pcdhold: got %h want 1c", PCD); end
        waitStates = 0;
        @(negedge clk);
        compared++; if (PCD !== 32'h100) begin mismatched++; $display("FAIL dr_pcd: got %h want 100", PCD); end
        compared++; if (ValidD !== 1'b1) begin mismatched++; $display("FAIL dr_valid2: got %h want 1", ValidD); end
        compared++; if (InstrD !== 32'h1000_0100) begin mismatched++; $display("FAIL dr_instr: got %h want 10000100", InstrD); end
        $display("test_redirect_drain: redirect to 0x100 during wait at 0x20");
    endtask

    task automatic test_hold_redirect_flush;
        StallF = 1; StallD = 1;
        @(negedge clk);
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL hr_req: got %h want 0", imem_req); end
        compared++; if (PCD !== 32'h100) begin mismatched++; $display("FAIL hr_pcdhold: got %h want 100", PCD); end
        PCSrcE = 1; PCTargetE = 32'h203; FlushD = 1;
        @(negedge clk);
        compared++; if (InstrD !== NOP) begin mismatched++; $display("FAIL hr_instr: got %h want %h", InstrD, NOP); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL hr_valid: got %h want 0", ValidD); end
        compared++; if (PCD !== 32'h0) begin mismatched++; $display("FAIL hr_pcd: got %h want 0", PCD); end
        compared++; if (imem_addr !== 32'h200) begin mismatched++; $display("FAIL hr_addr: got %h want 200", imem_addr); end
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL hr_req2: got %h want 1", imem_req); end
        StallF = 0; StallD = 0; PCSrcE = 0; PCTargetE = 0; FlushD = 0;
        @(negedge clk);
        compared++; if (PCD !== 32'h200) begin mismatched++; $display("FAIL hr_next_pcd: got %h want 200", PCD); end
        compared++; if (InstrD !== 32'h1000_0200) begin mismatched++; $display("FAIL hr_next_instr: got %h want 10000200", InstrD); end
        $display("test_hold_redirect_flush: held word dropped, fetch at 0x200");
    endtask

    task automatic test_reset_mid_wait;
        PCSrcE = 1; PCTargetE = 32'h40;
        @(negedge clk);
        compared++; if (imem_addr !== 32'h40) begin mismatched++; $display("FAIL rm_addr: got %h want 40", imem_addr); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL rm_discard: got %h want 0", ValidD); end
        PCSrcE = 0; PCTargetE = 0; manualMode = 1; manualValid = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rm_req: got %h want 0", imem_req); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL rm_pcf: got %h want 0", imem_addr); end
        compared++; if (InstrD !== NOP) begin mismatched++; $display("FAIL rm_instr: got %h want %h", InstrD, NOP); end
        compared++; if (PCD !== 32'h0) begin mismatched++; $display("FAIL rm_pcd: got %h want 0", PCD); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL rm_valid: got %h want 0", ValidD); end
        @(negedge clk);
        rst = 1'b0; manualValid = 1;
        @(negedge clk);
        compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL rm_req2: got %h want 1", imem_req); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL rm_addr2: got %h want 0", imem_addr); end
        compared++; if (ValidD !== 1'b0) begin mismatched++; $display("FAIL rm_ignored: got %h want 0", ValidD); end
        @(negedge clk);
        compared++; if (InstrD !== 32'h00A0_0093) begin mismatched++; $display("FAIL rm_instr2: got %h want 00a00093", InstrD); end
        compared++; if (ValidD !== 1'b1) begin mismatched++; $display("FAIL rm_valid2: got %h want 1", ValidD); end
        compared++; if (imem_addr !== 32'h4) begin mismatched++; $display("FAIL rm_addr3: got %h want 4", imem_addr); end
        $display("test_reset_mid_wait: reset during wait at 0x40, refetch from 0");
    endtask

    task automatic test_wrap;
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFF;
        @(negedge clk);
        compared++; if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr); end
        PCSrcE = 0; PCTargetE = 0;
        @(negedge clk);
        compared++; if (PCD !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wr_pcd: got %h want fffffffc", PCD); end
        compared++; if (PCPlus4D !== 32'h0) begin mismatched++; $display("FAIL wr_pcp4: got %h want 0", PCPlus4D); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("FAIL wr_pcf: got %h want 0", imem_addr); end
        $display("test_wrap: PC+4 wraps from fffffffc to 0");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_drain();
        test_hold_redirect_flush();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
